// File: rtl/kyber_pkg.sv
// Shared constants and FSM state type for the Kyber polynomial streamer.
// Optional build macro used by the streamer: KYBER_COEF_RANGE_CHECK_EN.
package kyber_pkg;

    localparam int KYBER_N      = 256;
    localparam int KYBER_Q      = 3329;
    localparam int KYBER_COEF_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/kyber_poly_streamer_if.sv
// RAM read port plus outgoing coefficient stream of the polynomial streamer.
// master = streamer side, slave = RAM / arithmetic-core side.
interface kyber_poly_streamer_if
    import kyber_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int COEF_W = KYBER_COEF_W
);

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [COEF_W-1:0] rd_data;
    logic              m_valid;
    logic              m_ready;
    logic [COEF_W-1:0] m_data;
    logic              m_last;

    modport master (
        output rd_en, rd_addr, m_valid, m_data, m_last,
        input  rd_data, m_ready
    );

    modport slave (
        input  rd_en, rd_addr, m_valid, m_data, m_last,
        output rd_data, m_ready
    );

endinterface

// File: rtl/kyber_poly_streamer_coef_skid_buf.sv
// Two-entry coefficient FIFO; entry 0 is always the head.
// Caller never writes when full nor pops when empty.
module coef_skid_buf
    import kyber_pkg::*;
#(
    parameter int W = KYBER_COEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem0_q, mem0_d;
    logic [W-1:0] mem1_q, mem1_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        mem0_d = mem0_q;
        mem1_d = mem1_q;
        cnt_d  = cnt_q;
        case ({wr_en, rd_en})
            2'b10: begin
                if (cnt_q == 2'd0) mem0_d = wr_data;
                else               mem1_d = wr_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                mem0_d = mem1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    mem0_d = wr_data;
                end else begin
                    mem0_d = mem1_q;
                    mem1_d = wr_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem0_q <= '0;
            mem1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head  = mem0_q;
    assign count = cnt_q;

endmodule

// File: rtl/kyber_poly_streamer.sv
// Streams one Kyber polynomial from coefficient RAM per start edge.
// Build macro KYBER_COEF_RANGE_CHECK_EN adds the sticky range_err output.
module kyber_poly_streamer
    import kyber_pkg::*;
#(
    parameter int N_COEFF = KYBER_N,
    parameter int COEF_W  = KYBER_COEF_W,
    parameter int SEL_W   = 2,
    parameter int ADDR_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SEL_W-1:0]      poly_sel,
    kyber_poly_streamer_if.master bus,
    output logic                  busy,
`ifdef KYBER_COEF_RANGE_CHECK_EN
    output logic                  done,
    output logic                  range_err
`else
    output logic                  done
`endif
);

    localparam int IDX_W = $clog2(N_COEFF) + 1;
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(N_COEFF);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_COEFF - 1);

    state_e             state_q, state_d;
    logic               start_prev_q;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               inflight_q;

    logic [COEF_W-1:0]  head;
    logic [1:0]         cnt;
    logic               accept;
    logic               valid;
    logic               pop;
    logic               last;
    logic               room;
    logic               rd_go;

    coef_skid_buf #(.W(COEF_W)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight_q),
        .wr_data (bus.rd_data),
        .rd_en   (pop),
        .head    (head),
        .count   (cnt)
    );

    // Occupancy is taken after this cycle's pop so a full-rate stream
    // (one buffered, one in flight) can keep issuing.
    always_comb begin
        accept = (state_q == IDLE) & start & ~start_prev_q;
        valid  = (cnt != 2'd0);
        pop    = valid & bus.m_ready;
        last   = valid & (out_idx_q == IDX_LAST);
        room   = (3'(cnt) - 3'(pop) + 3'(inflight_q)) < 3'd2;
        rd_go  = (state_q == RUN) & (rd_idx_q < IDX_END) & room;
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rd_idx_d  = rd_idx_q;
        out_idx_d = out_idx_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = RUN;
                    sel_d     = poly_sel;
                    rd_idx_d  = '0;
                    out_idx_d = '0;
                end
            end
            RUN: begin
                if (rd_go) rd_idx_d  = rd_idx_q + 1'b1;
                if (pop)   out_idx_d = out_idx_q + 1'b1;
                if (pop & last) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b0;
            sel_q        <= '0;
            rd_idx_q     <= '0;
            out_idx_q    <= '0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start;
            sel_q        <= sel_d;
            rd_idx_q     <= rd_idx_d;
            out_idx_q    <= out_idx_d;
            inflight_q   <= rd_go;
        end
    end

`ifdef KYBER_COEF_RANGE_CHECK_EN
    logic range_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            range_err_q <= 1'b0;
        end else if (accept) begin
            range_err_q <= 1'b0;
        end else if (pop && head >= COEF_W'(KYBER_Q)) begin
            range_err_q <= 1'b1;
        end
    end

    assign range_err = range_err_q;
`endif

    assign bus.rd_en   = rd_go;
    assign bus.rd_addr = rd_go ? (ADDR_W'(sel_q) * ADDR_W'(N_COEFF)
                                  + ADDR_W'(rd_idx_q)) : '0;
    assign bus.m_valid = valid;
    assign bus.m_data  = valid ? head : '0;
    assign bus.m_last  = last;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_kyber_poly_streamer.sv
// Directed bench for kyber_poly_streamer: table of transfers plus
// hand-written restart, DONE-edge and mid-transfer reset sequences.
module tb_kyber_poly_streamer;
    import kyber_pkg::*;

    typedef struct {
        int sel;
        bit rnd;
        int mode;
        int base;
        int cyc;
        int last;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] poly_sel;
    logic       busy;
    logic       done;
`ifdef KYBER_COEF_RANGE_CHECK_EN
    logic       range_err;
    bit         exp_re = 1'b0;
`endif

    kyber_poly_streamer_if #(.ADDR_W(10), .COEF_W(12)) bus ();

    kyber_poly_streamer #(
        .N_COEFF (256),
        .COEF_W  (12),
        .SEL_W   (2),
        .ADDR_W  (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .poly_sel  (poly_sel),
        .bus       (bus),
        .busy      (busy),
`ifdef KYBER_COEF_RANGE_CHECK_EN
        .done      (done),
        .range_err (range_err)
`else
        .done      (done)
`endif
    );

    logic [11:0] mem [1024];
    int checks = 0;
    int errors = 0;
    vec_t vecs [6];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.rd_en, bus.rd_addr, bus.m_valid, bus.m_data,
                     bus.m_last, busy, done});
    endfunction

    task automatic tick(input logic rdy);
        @(posedge clk);
        #1;
        bus.m_ready = rdy;
        #1;
    endtask

    task automatic run_xfer(input vec_t v);
        int n;
        int beats;
        int reads;
        bit prev_stall;
        logic [11:0] prev_data;
        logic prev_last;
        bit seen_rd;
        bit seen_v;
        bit fin;
        logic rdy;
        n = 0; beats = 0; reads = 0;
        prev_stall = 0; prev_data = '0; prev_last = 0;
        seen_rd = 0; seen_v = 0; fin = 0;
        poly_sel = 2'(v.sel);
        start = 1'b1;
        while (!fin) begin
            rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick(rdy);
            n++;
            if (n == 2) start = 1'b0;
            if (n == 1) chk("busy_after_accept", int'(busy), 1);
            if (v.mode == 1 && beats == 100) start = 1'b1;
`ifdef KYBER_COEF_RANGE_CHECK_EN
            if (n == 1) exp_re = 1'b0;
            chk("range_err", int'(range_err), int'(exp_re));
`endif
            if (prev_stall) begin
                chk("stall_valid", int'(bus.m_valid), 1);
                chk("stall_data", int'(bus.m_data), int'(prev_data));
                chk("stall_last", int'(bus.m_last), int'(prev_last));
            end
            if (bus.rd_en) begin
                if (!seen_rd && !v.rnd) chk("first_rd_cycle", n, 1);
                seen_rd = 1;
                chk("rd_addr", int'(bus.rd_addr), v.base + reads);
                reads++;
            end
            if (bus.m_valid && !seen_v) begin
                if (!v.rnd) chk("first_valid_cycle", n, 3);
                seen_v = 1;
            end
            if (bus.m_valid && rdy) begin
                chk("beat_data", int'(bus.m_data), int'(mem[v.base + beats]));
                chk("beat_last", int'(bus.m_last), int'(beats == 255));
                if (beats == 255) begin
                    chk("last_data", int'(bus.m_data), v.last);
                    if (!v.rnd) chk("last_beat_cycle", n, 258);
                end
`ifdef KYBER_COEF_RANGE_CHECK_EN
                if (bus.m_data >= 12'(KYBER_Q)) exp_re = 1'b1;
`endif
                beats++;
            end
            chk("occupancy_le_2", int'((reads - beats) <= 2), 1);
            prev_stall = bus.m_valid && !rdy;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
            if (done) begin
                fin = 1;
                chk("beats_total", beats, 256);
                chk("busy_on_done", int'(busy), 0);
                if (v.cyc != 0) chk("done_cycle", n, v.cyc);
            end else if (n > 3000) begin
                fin = 1;
                chk("done_timeout", 0, 1);
            end
        end
        if (v.mode == 2) start = 1'b1;
        if (v.mode == 0) begin
            tick(1'b1);
            chk("done_pulse_len", int'(done), 0);
            chk("idle_busy", int'(busy), 0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tick(1'b1);
                chk("no_restart_busy", int'(busy), 0);
                chk("no_restart_rd", int'(bus.rd_en), 0);
            end
            start = 1'b0;
            tick(1'b1);
        end
    endtask

    initial begin
        int n;
        int beats;
        vec_t rv;
        vecs[0] = '{sel: 0, rnd: 0, mode: 0, base: 0,   cyc: 259, last: 255};
        vecs[1] = '{sel: 2, rnd: 0, mode: 0, base: 512, cyc: 259, last: 90};
        vecs[2] = '{sel: 1, rnd: 1, mode: 0, base: 256, cyc: 0,   last: 3315};
        vecs[3] = '{sel: 3, rnd: 1, mode: 1, base: 768, cyc: 0,   last: 3073};
        vecs[4] = '{sel: 0, rnd: 0, mode: 2, base: 0,   cyc: 259, last: 255};
        vecs[5] = '{sel: 2, rnd: 1, mode: 0, base: 512, cyc: 0,   last: 90};
        for (int k = 0; k < 256; k++) begin
            mem[k]       = 12'(k);
            mem[256 + k] = 12'(k * 13);
            mem[512 + k] = 12'(k ^ 8'hA5);
            mem[768 + k] = 12'(3328 - k);
        end
        mem[256 + 7] = 12'd3329;

        rst = 1'b1;
        start = 1'b0;
        poly_sel = 2'd0;
        bus.m_ready = 1'b0;
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        chk("reset_outputs", outs(), 0);
`ifdef KYBER_COEF_RANGE_CHECK_EN
        chk("reset_range_err", int'(range_err), 0);
`endif
        rst = 1'b0;
        tick(1'b1);

        for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

        poly_sel = 2'd0;
        start = 1'b1;
        n = 0;
        beats = 0;
        while (beats < 50 && n < 1000) begin
            tick(1'b1);
            n++;
            if (n == 2) start = 1'b0;
            if (bus.m_valid) beats++;
        end
        chk("pre_reset_busy", int'(busy), 1);
        rst = 1'b1;
        tick(1'b1);
        chk("mid_reset_outputs", outs(), 0);
`ifdef KYBER_COEF_RANGE_CHECK_EN
        chk("mid_reset_range_err", int'(range_err), 0);
        exp_re = 1'b0;
`endif
        rst = 1'b0;
        tick(1'b1);
        chk("idle_after_reset", outs(), 0);
        rv = vecs[0];
        run_xfer(rv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
